// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing: pixel-enable divider, column/line counters,
// registered sync/visible decodes and one-clk pixel/line/frame pulses.

module vga_timing_gen_chk #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 783,
    parameter int V_TOTAL     = 521,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 32,
    parameter int V_VIS_END   = 511
) ();
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be 1..16");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit 10-bit counters");
    end
    if (!(H_SYNC < H_VIS_START && H_VIS_START <= H_VIS_END && H_VIS_END < H_TOTAL)) begin : g_bad_h
        $error("vga_timing_gen: illegal horizontal timing parameters");
    end
    if (!(V_SYNC < V_VIS_START && V_VIS_START <= V_VIS_END && V_VIS_END < V_TOTAL)) begin : g_bad_v
        $error("vga_timing_gen: illegal vertical timing parameters");
    end
endmodule

module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 783,
    parameter int V_TOTAL     = 521,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 32,
    parameter int V_VIS_END   = 511
) (
    input  logic       clk,
    input  logic       rst,
    output logic       HS,
    output logic       VS,
    output logic [9:0] Coloana,
    output logic [9:0] Linie,
    output logic       InDisplay,
    output logic       pix_tick,
    output logic       line_start,
    output logic       frame_start
);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_VS_W   = 10'(H_VIS_START);
    localparam logic [9:0] H_VE_W   = 10'(H_VIS_END);
    localparam logic [9:0] V_VS_W   = 10'(V_VIS_START);
    localparam logic [9:0] V_VE_W   = 10'(V_VIS_END);

    logic [3:0] div_cnt_r;
    logic [3:0] div_nxt_s;
    logic       adv_s;
    logic       col_wrap_s;
    logic [9:0] col_nxt_s;
    logic [9:0] lin_nxt_s;

    vga_timing_gen_chk #(
        .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC),
        .H_VIS_START(H_VIS_START), .H_VIS_END(H_VIS_END),
        .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
        .V_VIS_START(V_VIS_START), .V_VIS_END(V_VIS_END)
    ) u_chk ();

    // Next divider and raster position; outputs decode these so they stay aligned.
    always_comb begin
        adv_s      = (div_cnt_r == DIV_LAST);
        col_wrap_s = adv_s && (Coloana == H_LAST);
        if (adv_s) begin
            div_nxt_s = 4'd0;
        end else begin
            div_nxt_s = div_cnt_r + 4'd1;
        end
        if (!adv_s) begin
            col_nxt_s = Coloana;
        end else if (col_wrap_s) begin
            col_nxt_s = 10'd0;
        end else begin
            col_nxt_s = Coloana + 10'd1;
        end
        if (!col_wrap_s) begin
            lin_nxt_s = Linie;
        end else if (Linie == V_LAST) begin
            lin_nxt_s = 10'd0;
        end else begin
            lin_nxt_s = Linie + 10'd1;
        end
    end

    // Counter state plus registered sync, visible-window and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r   <= 4'd0;
            Coloana     <= 10'd0;
            Linie       <= 10'd0;
            HS          <= 1'b0;
            VS          <= 1'b0;
            InDisplay   <= 1'b0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt_r   <= div_nxt_s;
            Coloana     <= col_nxt_s;
            Linie       <= lin_nxt_s;
            HS          <= !(col_nxt_s < H_SYNC_W);
            VS          <= !(lin_nxt_s < V_SYNC_W);
            InDisplay   <= (col_nxt_s >= H_VS_W) && (col_nxt_s <= H_VE_W) &&
                           (lin_nxt_s >= V_VS_W) && (lin_nxt_s <= V_VE_W);
            pix_tick    <= adv_s;
            line_start  <= adv_s && (col_nxt_s == 10'd0);
            frame_start <= adv_s && (col_nxt_s == 10'd0) && (lin_nxt_s == 10'd0);
        end
    end
endmodule
